// File: rtl/complex_div_if.sv
// Valid/ready operand and result bundle for the sequential complex divider.
// The divider sits on the slave side; the producer/consumer uses master.
interface complex_div_if #(
  parameter int DIN_WIDTH = 16,
  parameter int OUT_WIDTH = 16
);
  logic                        din_valid;
  logic                        din_ready;
  logic signed [DIN_WIDTH-1:0] num_i;
  logic signed [DIN_WIDTH-1:0] num_q;
  logic signed [DIN_WIDTH-1:0] den_i;
  logic signed [DIN_WIDTH-1:0] den_q;
  logic                        dout_valid;
  logic                        dout_ready;
  logic signed [OUT_WIDTH-1:0] quo_i;
  logic signed [OUT_WIDTH-1:0] quo_q;
  logic                        div_zero;
  logic                        ovf;

  modport master (
    output din_valid, num_i, num_q, den_i, den_q, dout_ready,
    input  din_ready, dout_valid, quo_i, quo_q, div_zero, ovf
  );

  modport slave (
    input  din_valid, num_i, num_q, den_i, den_q, dout_ready,
    output din_ready, dout_valid, quo_i, quo_q, div_zero, ovf
  );
endinterface

// File: rtl/complex_div.sv
// Sequential complex divider q = num*conj(den)/|den|^2 with two restoring dividers sharing |den|^2.
// Define COMPLEX_DIV_ROUND_EN for round-half-away-from-zero (one extra DIV cycle); default truncates.
module complex_div #(
  parameter int DIN_WIDTH = 16,
  parameter int OUT_WIDTH = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic clk,
  input  logic rst,
  complex_div_if.slave bus
);

  localparam int PW = 2*DIN_WIDTH + 1;
  localparam int MW = 2*DIN_WIDTH;
  localparam int W  = 2*DIN_WIDTH + OUT_WIDTH + FRAC_BITS + 2;
`ifdef COMPLEX_DIV_ROUND_EN
  localparam int NB  = OUT_WIDTH;
  localparam int DSH = FRAC_BITS + 1;
`else
  localparam int NB  = OUT_WIDTH - 1;
  localparam int DSH = FRAC_BITS;
`endif
  localparam int CW = $clog2(NB + 1);
  localparam logic [OUT_WIDTH-1:0] MAXPOS = {1'b0, {(OUT_WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {IDLE, MULT, CHECK, DIV, DONE} state_t;

  state_t state, state_nx;

  logic signed [DIN_WIDTH-1:0] ni, nq, di, dq;
  logic signed [PW-1:0]        p_i, p_q, pi_nx, pq_nx;
  logic [MW-1:0]               m, m_nx;
  logic [PW-1:0]               api, apq;
  logic [W-1:0]                d_i, d_q, lim;
  logic [W-1:0]                rem_i, rem_q, rem_i_nx, rem_q_nx, dvs;
  logic [NB-1:0]               qa_i, qa_q, qn_i, qn_q;
  logic                        ge_i, ge_q;
  logic [CW-1:0]               cnt;
  logic                        neg_i, neg_q, sat_i, sat_q, zero;
  logic [OUT_WIDTH-1:0]        mag_i, mag_q, sel_i, sel_q, res_i, res_q;
  logic                        rov_i, rov_q, ovf_nx;
  logic [OUT_WIDTH-1:0]        quo_i_r, quo_q_r;
  logic                        div_zero_r, ovf_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.din_valid) state_nx = MULT;
      MULT:    state_nx = CHECK;
      CHECK:   state_nx = DIV;
      DIV:     if (cnt == CW'(NB-1)) state_nx = DONE;
      DONE:    if (bus.dout_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.din_ready  = (state == IDLE);
  assign bus.dout_valid = (state == DONE);
  assign bus.quo_i      = quo_i_r;
  assign bus.quo_q      = quo_q_r;
  assign bus.div_zero   = div_zero_r;
  assign bus.ovf        = ovf_r;

  // Exact cross products and |den|^2; widened before multiplying so nothing wraps.
  always_comb begin
    pi_nx = PW'(ni) * PW'(di) + PW'(nq) * PW'(dq);
    pq_nx = PW'(nq) * PW'(di) - PW'(ni) * PW'(dq);
    m_nx  = MW'(PW'(di) * PW'(di) + PW'(dq) * PW'(dq));
  end

  always_comb begin
    api = p_i[PW-1] ? PW'(-p_i) : PW'(p_i);
    apq = p_q[PW-1] ? PW'(-p_q) : PW'(p_q);
    d_i = W'(api) << DSH;
    d_q = W'(apq) << DSH;
    lim = W'(m) << (OUT_WIDTH - 1 + DSH - FRAC_BITS);
  end

  always_comb begin
    ge_i     = (rem_i >= dvs);
    ge_q     = (rem_q >= dvs);
    rem_i_nx = ge_i ? rem_i - dvs : rem_i;
    rem_q_nx = ge_q ? rem_q - dvs : rem_q;
    qn_i     = {qa_i[NB-2:0], ge_i};
    qn_q     = {qa_q[NB-2:0], ge_q};
  end

  // In rounding builds the last quotient bit is the half bit; a carry into the sign position saturates.
  always_comb begin
`ifdef COMPLEX_DIV_ROUND_EN
    mag_i = {1'b0, qn_i[NB-1:1]} + OUT_WIDTH'(qn_i[0]);
    mag_q = {1'b0, qn_q[NB-1:1]} + OUT_WIDTH'(qn_q[0]);
    rov_i = mag_i[OUT_WIDTH-1];
    rov_q = mag_q[OUT_WIDTH-1];
`else
    mag_i = {1'b0, qn_i};
    mag_q = {1'b0, qn_q};
    rov_i = 1'b0;
    rov_q = 1'b0;
`endif
    sel_i  = (sat_i || rov_i) ? MAXPOS : mag_i;
    sel_q  = (sat_q || rov_q) ? MAXPOS : mag_q;
    res_i  = zero ? '0 : (neg_i ? -sel_i : sel_i);
    res_q  = zero ? '0 : (neg_q ? -sel_q : sel_q);
    ovf_nx = !zero && (sat_i || rov_i || sat_q || rov_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ni <= '0; nq <= '0; di <= '0; dq <= '0;
      p_i <= '0; p_q <= '0; m <= '0;
      neg_i <= 1'b0; neg_q <= 1'b0; sat_i <= 1'b0; sat_q <= 1'b0; zero <= 1'b0;
      rem_i <= '0; rem_q <= '0; dvs <= '0;
      qa_i <= '0; qa_q <= '0; cnt <= '0;
      quo_i_r <= '0; quo_q_r <= '0; div_zero_r <= 1'b0; ovf_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.din_valid) begin
          ni <= bus.num_i; nq <= bus.num_q;
          di <= bus.den_i; dq <= bus.den_q;
          quo_i_r <= '0; quo_q_r <= '0;
          div_zero_r <= 1'b0; ovf_r <= 1'b0;
        end
        MULT: begin
          p_i <= pi_nx; p_q <= pq_nx; m <= m_nx;
        end
        // A zero divisor still walks the DIV cycles so every result has the same latency.
        CHECK: begin
          neg_i <= p_i[PW-1];
          neg_q <= p_q[PW-1];
          zero  <= (m == '0);
          sat_i <= (d_i >= lim);
          sat_q <= (d_q >= lim);
          rem_i <= d_i;
          rem_q <= d_q;
          dvs   <= W'(m) << (NB - 1);
          qa_i  <= '0;
          qa_q  <= '0;
          cnt   <= '0;
        end
        DIV: begin
          rem_i <= rem_i_nx;
          rem_q <= rem_q_nx;
          qa_i  <= qn_i;
          qa_q  <= qn_q;
          dvs   <= dvs >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(NB-1)) begin
            quo_i_r    <= res_i;
            quo_q_r    <= res_q;
            div_zero_r <= zero;
            ovf_r      <= ovf_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_div.sv
// Randomised and directed bench for complex_div against an integer-arithmetic reference model.
// Expectations follow COMPLEX_DIV_ROUND_EN when it is defined for the build.
module tb_complex_div;

  localparam int DIN_WIDTH = 16;
  localparam int OUT_WIDTH = 16;
  localparam int FRAC_BITS = 8;
`ifdef COMPLEX_DIV_ROUND_EN
  localparam int EXP_LAT = OUT_WIDTH + 2;
`else
  localparam int EXP_LAT = OUT_WIDTH + 1;
`endif

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  complex_div_if #(.DIN_WIDTH(DIN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

  complex_div #(.DIN_WIDTH(DIN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .FRAC_BITS(FRAC_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    vectors++;
    if (observed != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Quotient component straight from the arithmetic definition: scale, divide, saturate, re-sign.
  function automatic longint refComp(input longint p, input longint m, output bit sat);
    longint a, mag, maxv;
    maxv = (longint'(1) << (OUT_WIDTH - 1)) - 1;
    a = (p < 0) ? -p : p;
`ifdef COMPLEX_DIV_ROUND_EN
    mag = ((a << (FRAC_BITS + 1)) + m) / (2 * m);
`else
    mag = (a << FRAC_BITS) / m;
`endif
    sat = (mag > maxv);
    if (sat) mag = maxv;
    return (p < 0) ? -mag : mag;
  endfunction

  task automatic refModel(input logic signed [DIN_WIDTH-1:0] a, b, c, d,
                          output longint ei, eq, output bit eov, edz);
    longint pi, pq, m;
    bit si, sq;
    pi = longint'(a) * longint'(c) + longint'(b) * longint'(d);
    pq = longint'(b) * longint'(c) - longint'(a) * longint'(d);
    m  = longint'(c) * longint'(c) + longint'(d) * longint'(d);
    if (m == 0) begin
      ei = 0; eq = 0; eov = 1'b0; edz = 1'b1;
    end else begin
      ei  = refComp(pi, m, si);
      eq  = refComp(pq, m, sq);
      eov = si | sq;
      edz = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic signed [DIN_WIDTH-1:0] a, b, c, d);
    int guard;
    guard = 0;
    while (!bus.din_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("accept_ready", longint'(bus.din_ready), 1);
    bus.num_i = a; bus.num_q = b; bus.den_i = c; bus.den_q = d;
    bus.din_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.din_valid = 1'b0;
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.dout_valid && lat < 100);
  endtask

  task automatic handoff();
    bus.dout_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.dout_ready = 1'b0;
    checkOutput("after_handoff_valid", longint'(bus.dout_valid), 0);
  endtask

  task automatic checkResult(input logic signed [DIN_WIDTH-1:0] a, b, c, d, input int lat);
    longint ei, eq;
    bit eov, edz;
    refModel(a, b, c, d, ei, eq, eov, edz);
    checkOutput("latency", lat, EXP_LAT);
    checkOutput("quo_i", longint'(bus.quo_i), ei);
    checkOutput("quo_q", longint'(bus.quo_q), eq);
    checkOutput("ovf", longint'(bus.ovf), longint'(eov));
    checkOutput("div_zero", longint'(bus.div_zero), longint'(edz));
  endtask

  task automatic runVector(input logic signed [DIN_WIDTH-1:0] a, b, c, d);
    int lat;
    applyStimulus(a, b, c, d);
    waitResult(lat);
    checkResult(a, b, c, d, lat);
    handoff();
  endtask

  initial begin
    int lat;
    logic signed [DIN_WIDTH-1:0] ra, rb, rc, rd;
    longint ei, eq;
    bit eov, edz;
    vectors = 0;
    miscompares = 0;
    bus.din_valid = 1'b0; bus.dout_ready = 1'b0;
    bus.num_i = '0; bus.num_q = '0; bus.den_i = '0; bus.den_q = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_din_ready", longint'(bus.din_ready), 1);
    checkOutput("reset_dout_valid", longint'(bus.dout_valid), 0);
    checkOutput("reset_quo_i", longint'(bus.quo_i), 0);
    checkOutput("reset_ovf", longint'(bus.ovf), 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed points with hand-derived answers, then model-checked corners
    applyStimulus(16'sd100, 16'sd0, 16'sd50, 16'sd0);
    waitResult(lat);
    checkOutput("dir_100_50_lat", lat, EXP_LAT);
    checkOutput("dir_100_50_i", longint'(bus.quo_i), 512);
    checkOutput("dir_100_50_q", longint'(bus.quo_q), 0);
    handoff();

    applyStimulus(16'sd1, 16'sd1, 16'sd1, -16'sd1);
    waitResult(lat);
    checkOutput("dir_j_i", longint'(bus.quo_i), 0);
    checkOutput("dir_j_q", longint'(bus.quo_q), 256);
    handoff();

    applyStimulus(16'sd2, 16'sd0, 16'sd3, 16'sd0);
    waitResult(lat);
`ifdef COMPLEX_DIV_ROUND_EN
    checkOutput("dir_2_3_i", longint'(bus.quo_i), 171);
`else
    checkOutput("dir_2_3_i", longint'(bus.quo_i), 170);
`endif
    handoff();

    applyStimulus(16'sd123, -16'sd45, 16'sd0, 16'sd0);
    waitResult(lat);
    checkOutput("dir_zero_dz", longint'(bus.div_zero), 1);
    checkOutput("dir_zero_lat", lat, EXP_LAT);
    checkOutput("dir_zero_i", longint'(bus.quo_i), 0);
    checkOutput("dir_zero_ovf", longint'(bus.ovf), 0);
    handoff();

    applyStimulus(16'sd32767, 16'sd0, 16'sd1, 16'sd0);
    waitResult(lat);
    checkOutput("dir_satp_i", longint'(bus.quo_i), 32767);
    checkOutput("dir_satp_ovf", longint'(bus.ovf), 1);
    handoff();

    applyStimulus(-16'sd32768, 16'sd0, 16'sd1, 16'sd0);
    waitResult(lat);
    checkOutput("dir_satn_i", longint'(bus.quo_i), -32767);
    checkOutput("dir_satn_ovf", longint'(bus.ovf), 1);
    handoff();

    runVector(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768);
    runVector(16'sd7, -16'sd3, -16'sd2, 16'sd5);
    runVector(-16'sd1000, 16'sd999, 16'sd250, -16'sd251);

    // Result held under back-pressure while a new operand pulse is offered
    applyStimulus(16'sd300, -16'sd700, 16'sd40, 16'sd9);
    waitResult(lat);
    checkResult(16'sd300, -16'sd700, 16'sd40, 16'sd9, lat);
    refModel(16'sd300, -16'sd700, 16'sd40, 16'sd9, ei, eq, eov, edz);
    for (int k = 0; k < 5; k++) begin
      bus.din_valid = (k == 2);
      bus.num_i = 16'sd5; bus.num_q = 16'sd5; bus.den_i = 16'sd1; bus.den_q = 16'sd0;
      @(negedge clk);
      checkOutput("stall_valid", longint'(bus.dout_valid), 1);
      checkOutput("stall_ready", longint'(bus.din_ready), 0);
      checkOutput("stall_quo_i", longint'(bus.quo_i), ei);
      checkOutput("stall_quo_q", longint'(bus.quo_q), eq);
    end
    bus.din_valid = 1'b0;
    handoff();
    repeat (3) @(negedge clk);
    checkOutput("no_capture_valid", longint'(bus.dout_valid), 0);
    checkOutput("no_capture_ready", longint'(bus.din_ready), 1);

    // Reset partway through the divide iterations
    applyStimulus(16'sd12345, 16'sd2222, 16'sd77, -16'sd33);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", longint'(bus.dout_valid), 0);
    checkOutput("midrst_ready", longint'(bus.din_ready), 1);
    checkOutput("midrst_quo_i", longint'(bus.quo_i), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    runVector(16'sd12345, 16'sd2222, 16'sd77, -16'sd33);

    // Reset while a non-zero result is being held
    applyStimulus(16'sd5000, 16'sd4000, 16'sd3, 16'sd4);
    waitResult(lat);
    checkResult(16'sd5000, 16'sd4000, 16'sd3, 16'sd4, lat);
    rst = 1'b1;
    #1;
    checkOutput("donerst_valid", longint'(bus.dout_valid), 0);
    checkOutput("donerst_quo_i", longint'(bus.quo_i), 0);
    checkOutput("donerst_quo_q", longint'(bus.quo_q), 0);
    checkOutput("donerst_ovf", longint'(bus.ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 60; n++) begin
      ra = DIN_WIDTH'($urandom);
      rb = DIN_WIDTH'($urandom);
      rc = DIN_WIDTH'($urandom);
      rd = DIN_WIDTH'($urandom);
      ra = ra >>> $urandom_range(0, 12);
      rb = rb >>> $urandom_range(0, 12);
      rc = rc >>> $urandom_range(0, 8);
      rd = rd >>> $urandom_range(0, 8);
      if ($urandom_range(0, 15) == 0) rd = '0;
      runVector(ra, rb, rc, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
